// File: rtl/vu_stereo_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vu_pkg
// Brief   : Shared types for the stereo VU envelope scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package vu_pkg;

  typedef logic        [31:0] level_t;
  typedef logic signed [23:0] sample_t;
  typedef logic        [31:0] hold_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_L = 2'd1,
    CALC_R = 2'd2,
    DONE   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_LEFT  = 2'd0,
    SEL_RIGHT = 2'd1,
    SEL_MAX   = 2'd2,
    SEL_ALT   = 2'd3
  } disp_sel_e;

endpackage
`default_nettype wire

// File: rtl/vu_stereo_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : vu_stereo_scheduler_if
// Brief   : Sample strobe in, level/peak/display results out.
// Revision: 1.0 - initial release
// ============================================================================
interface vu_stereo_scheduler_if;
  import vu_pkg::*;

  logic        sample_stb_i;
  sample_t     left_sample_i;
  sample_t     right_sample_i;
  logic [1:0]  sel_i;
  logic        busy_o;
  logic        levels_valid_o;
  level_t      level_l_o;
  level_t      level_r_o;
  level_t      peak_l_o;
  level_t      peak_r_o;
  level_t      disp_level_o;
  level_t      disp_peak_o;
  logic        disp_is_right_o;
  logic [7:0]  overrun_cnt_o;

  // Scheduler side
  modport slave (
    input  sample_stb_i, left_sample_i, right_sample_i, sel_i,
    output busy_o, levels_valid_o, level_l_o, level_r_o, peak_l_o, peak_r_o,
           disp_level_o, disp_peak_o, disp_is_right_o, overrun_cnt_o
  );

  // Sample source / display consumer side
  modport master (
    output sample_stb_i, left_sample_i, right_sample_i, sel_i,
    input  busy_o, levels_valid_o, level_l_o, level_r_o, peak_l_o, peak_r_o,
           disp_level_o, disp_peak_o, disp_is_right_o, overrun_cnt_o
  );

endinterface
`default_nettype wire

// File: rtl/vu_stereo_scheduler_env_update.sv
`default_nettype none
// ============================================================================
// Module  : vu_env_update
// Brief   : Combinational envelope + peak-hold step for one channel.
// Revision: 1.0 - initial release
// ============================================================================
module vu_env_update
  import vu_pkg::*;
#(
  parameter int DECAY_SHIFT = 11,
  parameter int SCALE_SHIFT = 8,
  parameter int PEAK_HOLD   = 24000
) (
  input  sample_t sample,
  input  level_t  level,
  input  level_t  peak,
  input  hold_t   hold,
  output level_t  new_level,
  output level_t  new_peak,
  output hold_t   new_hold
);

  logic [23:0] mag;
  logic [32:0] sum;

  // Leaky integrator of |sample|, then peak-hold decision on the new level
  always_comb begin
    // Two's-complement negate of the most negative value yields 0x800000,
    // which read as unsigned is exactly its magnitude.
    mag       = sample[23] ? 24'(-sample) : 24'(sample);
    sum       = {1'b0, level} - {1'b0, level >> DECAY_SHIFT} + {9'd0, mag >> SCALE_SHIFT};
    new_level = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    new_peak  = peak;
    new_hold  = hold;
    if (new_level >= peak) begin
      new_peak = new_level;
      new_hold = hold_t'(PEAK_HOLD);
    end else if (hold == '0) begin
      new_peak = new_level;
    end else begin
      new_hold = hold - hold_t'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vu_stereo_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : vu_stereo_scheduler
// Brief   : Time-shares one envelope datapath over left/right channels and
//           presents a selectable display channel.
// Revision: 1.0 - initial release
// ============================================================================
module vu_stereo_scheduler
  import vu_pkg::*;
#(
  parameter int DECAY_SHIFT = 11,
  parameter int SCALE_SHIFT = 8,
  parameter int PEAK_HOLD   = 24000,
  parameter int ALT_SAMPLES = 48000
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  vu_stereo_scheduler_if.slave   bus
);

  localparam logic [31:0] C_ALT_LAST = 32'(ALT_SAMPLES - 1);

  state_e      state;
  sample_t     smp_l, smp_r;
  level_t      level_l, level_r, peak_l, peak_r;
  hold_t       hold_l, hold_r;
  level_t      disp_level, disp_peak;
  logic        disp_is_right;
  logic        valid;
  logic [7:0]  overrun_cnt;
  logic [31:0] alt_cnt;
  logic        alt_tog;

  sample_t upd_sample;
  level_t  upd_level, upd_peak, upd_new_level, upd_new_peak;
  hold_t   upd_hold, upd_new_hold;
  logic    pick_right;

  // Route the active channel's state into the shared datapath
  always_comb begin
    upd_sample = smp_l;
    upd_level  = level_l;
    upd_peak   = peak_l;
    upd_hold   = hold_l;
    if (state == CALC_R) begin
      upd_sample = smp_r;
      upd_level  = level_r;
      upd_peak   = peak_r;
      upd_hold   = hold_r;
    end
  end

  vu_env_update #(
    .DECAY_SHIFT (DECAY_SHIFT),
    .SCALE_SHIFT (SCALE_SHIFT),
    .PEAK_HOLD   (PEAK_HOLD)
  ) u_env_update (
    .sample    (upd_sample),
    .level     (upd_level),
    .peak      (upd_peak),
    .hold      (upd_hold),
    .new_level (upd_new_level),
    .new_peak  (upd_new_peak),
    .new_hold  (upd_new_hold)
  );

  // Display channel choice; only consumed in CALC_R, where left is already
  // registered and right is the datapath output.
  always_comb begin
    pick_right = 1'b0;
    case (disp_sel_e'(bus.sel_i))
      SEL_LEFT:  pick_right = 1'b0;
      SEL_RIGHT: pick_right = 1'b1;
      SEL_MAX:   pick_right = (upd_new_level > level_l);
      SEL_ALT:   pick_right = alt_tog;
      default:   pick_right = 1'b0;
    endcase
  end

  // Sequencer FSM with all channel state and registered outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state         <= IDLE;
      smp_l         <= '0;
      smp_r         <= '0;
      level_l       <= '0;
      level_r       <= '0;
      peak_l        <= '0;
      peak_r        <= '0;
      hold_l        <= '0;
      hold_r        <= '0;
      disp_level    <= '0;
      disp_peak     <= '0;
      disp_is_right <= 1'b0;
      valid         <= 1'b0;
      overrun_cnt   <= '0;
      alt_cnt       <= '0;
      alt_tog       <= 1'b0;
    end else begin
      valid <= 1'b0;

      if (bus.sample_stb_i && (state == CALC_L || state == CALC_R) &&
          overrun_cnt != 8'hFF) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end

      if (state == DONE) begin
        if (alt_cnt == C_ALT_LAST) begin
          alt_cnt <= '0;
          alt_tog <= ~alt_tog;
        end else begin
          alt_cnt <= alt_cnt + 32'd1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (bus.sample_stb_i) begin
            smp_l <= bus.left_sample_i;
            smp_r <= bus.right_sample_i;
            state <= CALC_L;
          end else begin
            state <= IDLE;
          end
        end
        CALC_L: begin
          level_l <= upd_new_level;
          peak_l  <= upd_new_peak;
          hold_l  <= upd_new_hold;
          state   <= CALC_R;
        end
        CALC_R: begin
          level_r       <= upd_new_level;
          peak_r        <= upd_new_peak;
          hold_r        <= upd_new_hold;
          disp_is_right <= pick_right;
          disp_level    <= pick_right ? upd_new_level : level_l;
          disp_peak     <= pick_right ? upd_new_peak  : peak_l;
          valid         <= 1'b1;
          state         <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o          = (state == CALC_L) || (state == CALC_R);
  assign bus.levels_valid_o  = valid;
  assign bus.level_l_o       = level_l;
  assign bus.level_r_o       = level_r;
  assign bus.peak_l_o        = peak_l;
  assign bus.peak_r_o        = peak_r;
  assign bus.disp_level_o    = disp_level;
  assign bus.disp_peak_o     = disp_peak;
  assign bus.disp_is_right_o = disp_is_right;
  assign bus.overrun_cnt_o   = overrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vu_stereo_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_vu_stereo_scheduler
// Brief   : Directed self-checking bench for vu_stereo_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vu_stereo_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  vu_stereo_scheduler_if bus ();

  vu_stereo_scheduler #(
    .DECAY_SHIFT (11),
    .SCALE_SHIFT (8),
    .PEAK_HOLD   (2),
    .ALT_SAMPLES (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.sample_stb_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Strobe once and wait (bounded) for the valid pulse.
  task automatic do_seq(input logic signed [23:0] l, input logic signed [23:0] r,
                        output int lat, output int busy_n);
    bus.left_sample_i  = l;
    bus.right_sample_i = r;
    bus.sample_stb_i   = 1'b1;
    tick();
    bus.sample_stb_i   = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (!bus.levels_valid_o && lat < 8) begin
      if (bus.busy_o) busy_n++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bn, pulses;
    bus.sample_stb_i   = 1'b0;
    bus.left_sample_i  = '0;
    bus.right_sample_i = '0;
    bus.sel_i          = 2'd0;

    // Reset state
    do_reset();
    chk("rst_level_l", bus.level_l_o, 0);
    chk("rst_valid", {31'd0, bus.levels_valid_o}, 0);
    chk("rst_busy", {31'd0, bus.busy_o}, 0);
    chk("rst_overrun", {24'd0, bus.overrun_cnt_o}, 0);

    // First sequence: 25600>>8 = 100 on both channels
    do_seq(24'sd25600, -24'sd25600, lat, bn);
    chk("latency", lat, 3);
    chk("busy_cycles", bn, 2);
    chk("lvl_l_100", bus.level_l_o, 100);
    chk("lvl_r_100", bus.level_r_o, 100);
    chk("pk_l_100", bus.peak_l_o, 100);
    chk("pk_r_100", bus.peak_r_o, 100);
    tick();
    chk("valid_one_cycle", {31'd0, bus.levels_valid_o}, 0);
    do_seq(24'sd25600, -24'sd25600, lat, bn);
    chk("lvl_l_200", bus.level_l_o, 200);
    chk("lvl_r_200", bus.level_r_o, 200);
    chk("disp_sel0", bus.disp_level_o, 200);
    chk("disp_sel0_side", {31'd0, bus.disp_is_right_o}, 0);
    tick();

    // Decay and peak hold (hold=2): 4096 -> 4094 -> 4093 -> 4092
    do_reset();
    do_seq(24'sd1048576, 24'sd0, lat, bn);
    chk("preload_4096", bus.level_l_o, 4096);
    tick();
    do_seq(24'sd0, 24'sd0, lat, bn);
    chk("decay_4094", bus.level_l_o, 4094);
    chk("hold_pk1", bus.peak_l_o, 4096);
    tick();
    do_seq(24'sd0, 24'sd0, lat, bn);
    chk("decay_4093", bus.level_l_o, 4093);
    chk("hold_pk2", bus.peak_l_o, 4096);
    tick();
    do_seq(24'sd0, 24'sd0, lat, bn);
    chk("decay_4092", bus.level_l_o, 4092);
    chk("pk_follows", bus.peak_l_o, 4092);
    tick();

    // Overrun: second strobe one cycle later is dropped
    do_reset();
    bus.left_sample_i  = 24'sd25600;
    bus.right_sample_i = 24'sd0;
    bus.sample_stb_i   = 1'b1;
    tick();
    bus.left_sample_i  = 24'sd51200;
    tick();
    bus.sample_stb_i   = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.levels_valid_o) pulses++;
    end
    chk("ovr_pulses", pulses, 1);
    chk("ovr_cnt1", {24'd0, bus.overrun_cnt_o}, 1);
    chk("ovr_samples_kept", bus.level_l_o, 100);

    // Strobes every 3 cycles are lossless
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      bus.sample_stb_i = 1'b1;
      tick();
      if (bus.levels_valid_o) pulses++;
      bus.sample_stb_i = 1'b0;
      tick();
      if (bus.levels_valid_o) pulses++;
      tick();
      if (bus.levels_valid_o) pulses++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.levels_valid_o) pulses++;
    end
    chk("every3_pulses", pulses, 10);
    chk("every3_no_drop", {24'd0, bus.overrun_cnt_o}, 1);

    // Continuous strobes saturate the overrun counter
    bus.sample_stb_i = 1'b1;
    repeat (450) tick();
    bus.sample_stb_i = 1'b0;
    repeat (4) tick();
    chk("ovr_saturate", {24'd0, bus.overrun_cnt_o}, 255);

    // Max select
    do_reset();
    bus.sel_i = 2'd2;
    do_seq(24'sd51200, 24'sd25600, lat, bn);
    chk("max_level", bus.disp_level_o, 200);
    chk("max_side_l", {31'd0, bus.disp_is_right_o}, 0);
    tick();
    do_seq(24'sd25600, 24'sd51200, lat, bn);
    chk("tie_level", bus.disp_level_o, 300);
    chk("tie_side_l", {31'd0, bus.disp_is_right_o}, 0);
    tick();
    do_seq(24'sd0, 24'sd25600, lat, bn);
    chk("max_r_level", bus.disp_level_o, 400);
    chk("max_r_peak", bus.disp_peak_o, 400);
    chk("max_side_r", {31'd0, bus.disp_is_right_o}, 1);
    tick();
    bus.sel_i = 2'd0;
    do_seq(24'sd0, 24'sd0, lat, bn);
    chk("sel0_level", bus.disp_level_o, 300);
    chk("sel0_side", {31'd0, bus.disp_is_right_o}, 0);
    tick();
    bus.sel_i = 2'd1;
    do_seq(24'sd0, 24'sd0, lat, bn);
    chk("sel1_level", bus.disp_level_o, 400);
    chk("sel1_side", {31'd0, bus.disp_is_right_o}, 1);
    tick();

    // Alternate select: flips every 4 sequences, starting on left
    do_reset();
    bus.sel_i = 2'd3;
    for (int i = 0; i < 12; i++) begin
      do_seq(24'sd0, 24'sd0, lat, bn);
      chk($sformatf("alt_%0d", i), {31'd0, bus.disp_is_right_o}, ((i / 4) % 2));
      tick();
    end
    bus.sel_i = 2'd0;

    // Reset in CALC_R wipes the partial sequence
    do_reset();
    bus.left_sample_i  = 24'sd25600;
    bus.right_sample_i = 24'sd25600;
    bus.sample_stb_i   = 1'b1;
    tick();
    bus.sample_stb_i   = 1'b0;
    tick();
    chk("pre_rst_lvl_l", bus.level_l_o, 100);
    rst_n = 1'b0;
    tick();
    chk("midrst_lvl_l", bus.level_l_o, 0);
    chk("midrst_lvl_r", bus.level_r_o, 0);
    chk("midrst_busy", {31'd0, bus.busy_o}, 0);
    chk("midrst_valid", {31'd0, bus.levels_valid_o}, 0);
    rst_n = 1'b1;
    tick();
    chk("postrst_valid", {31'd0, bus.levels_valid_o}, 0);

    // Extreme magnitudes
    do_seq(-24'sd8388608, 24'sd8388607, lat, bn);
    chk("mag_min_neg", bus.level_l_o, 32768);
    chk("mag_max_pos", bus.level_r_o, 32767);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
